// File: rtl/gpr_wb_queue.sv
// gpr_wb_queue
//   In-order write-back buffer between the execute/load result sources and
//   the single GPR write port. It absorbs cycles where the write port is busy
//   (for example during load/store-multiple sequencing), and it can optionally
//   expose pending, not-yet-written values to the read side.
//
//   Configuration macro: GPR_WB_BYPASS_EN
//     defined   : lk_hit/lk_data perform a combinational lookup over pending entries
//     undefined : lk_hit=0, lk_data=0, no compare logic is built
//
//   Parameters
//     DEPTH  queue entries (power of two, >= 2)
//     AW     log2(DEPTH), pointer width
//     DW     data width (normally instantiated with `ARCH_WIDTH)
//
//   Ports
//     clk       in   rising-edge clock
//     rst_n     in   asynchronous reset, active-low; discards pending entries
//     wb_valid  in   result write-back request
//     wb_ready  out  queue can accept this cycle (state only, no wb_valid path)
//     wb_rd     in   destination GPR index
//     wb_data   in   result value
//     gpr_busy  in   GPR write port unavailable this cycle
//     gpr_we    out  GPR write enable
//     gpr_wa    out  GPR write address
//     gpr_wd    out  GPR write data
//     occ       out  current entry count, 0..DEPTH
//     lk_ra     in   bypass lookup index
//     lk_hit    out  a pending entry targets lk_ra
//     lk_data   out  data of the youngest matching pending entry
module gpr_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_valid,
  output logic          wb_ready,
  input  logic [4:0]    wb_rd,
  input  logic [DW-1:0] wb_data,
  input  logic          gpr_busy,
  output logic          gpr_we,
  output logic [4:0]    gpr_wa,
  output logic [DW-1:0] gpr_wd,
  output logic [AW:0]   occ,
  input  logic [4:0]    lk_ra,
  output logic          lk_hit,
  output logic [DW-1:0] lk_data
);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [4:0]    rd_mem   [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [AW-1:0] hp;
  logic [AW-1:0] tp;
  logic [AW:0]   cnt;
  logic          enq;

  // Full/empty come from cnt alone; pointers are only used for addressing.
  assign wb_ready = (cnt != CNT_FULL);
  assign enq      = wb_valid & wb_ready;
  assign gpr_we   = (cnt != '0) & ~gpr_busy;
  assign gpr_wa   = rd_mem[hp];
  assign gpr_wd   = data_mem[hp];
  assign occ      = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp  <= '0;
      tp  <= '0;
      cnt <= '0;
    end else begin
      if (enq)
        tp <= tp + PTR_ONE;
      if (gpr_we)
        hp <= hp + PTR_ONE;
      if (enq && !gpr_we)
        cnt <= cnt + CNT_ONE;
      else if (!enq && gpr_we)
        cnt <= cnt - CNT_ONE;
    end
  end

  // Entry contents need no reset: occupancy is tracked by cnt.
  always_ff @(posedge clk) begin
    if (enq) begin
      rd_mem[tp]   <= wb_rd;
      data_mem[tp] <= wb_data;
    end
  end

`ifdef GPR_WB_BYPASS_EN
  // Walk entries oldest to youngest so the last match (the youngest) wins.
  // The head entry still counts while it is being dequeued this cycle.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((i < int'(cnt)) && (rd_mem[hp + AW'(i)] == lk_ra)) begin
        lk_hit  = 1'b1;
        lk_data = data_mem[hp + AW'(i)];
      end
    end
  end
`else
  logic unused_lk;
  assign unused_lk = ^lk_ra;
  assign lk_hit    = 1'b0;
  assign lk_data   = '0;
`endif

endmodule

// File: tb/tb_gpr_wb_queue.sv
module tb_gpr_wb_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wb_valid = 1'b0;
  logic          wb_ready;
  logic [4:0]    wb_rd = '0;
  logic [DW-1:0] wb_data = '0;
  logic          gpr_busy = 1'b0;
  logic          gpr_we;
  logic [4:0]    gpr_wa;
  logic [DW-1:0] gpr_wd;
  logic [AW:0]   occ;
  logic [4:0]    lk_ra = '0;
  logic          lk_hit;
  logic [DW-1:0] lk_data;

  gpr_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .gpr_busy(gpr_busy), .gpr_we(gpr_we), .gpr_wa(gpr_wa), .gpr_wd(gpr_wd),
    .occ(occ), .lk_ra(lk_ra), .lk_hit(lk_hit), .lk_data(lk_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  typedef struct {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t m_q[$];   // pending entries, oldest first
  ent_t wlog[$];  // writes the model says reached the GPR

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of accepted writes.
  bit m_rdy, m_we;
  always @(negedge rst_n) m_q.delete();
  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
    end else begin
      m_rdy = (m_q.size() != DEPTH);
      m_we  = (m_q.size() != 0) && !gpr_busy;
      if (m_we) begin
        wlog.push_back(m_q[0]);
        void'(m_q.pop_front());
      end
      if (wb_valid && m_rdy)
        m_q.push_back(ent_t'{wb_rd, wb_data});
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  int            c_n;
  bit            c_we;
  bit            c_hit;
  logic [DW-1:0] c_data;
  always @(negedge clk) begin
    if (check_en) begin
      c_n  = m_q.size();
      c_we = (c_n != 0) && !gpr_busy;
      chk("occ", 32'(occ), 32'(c_n));
      chk("wb_ready", 32'(wb_ready), 32'(c_n != DEPTH));
      chk("gpr_we", 32'(gpr_we), 32'(c_we));
      if (c_we) begin
        chk("gpr_wa", 32'(gpr_wa), 32'(m_q[0].rd));
        chk("gpr_wd", gpr_wd, m_q[0].data);
      end
      c_hit  = 1'b0;
      c_data = '0;
`ifdef GPR_WB_BYPASS_EN
      for (int i = c_n - 1; i >= 0; i--) begin
        if (!c_hit && m_q[i].rd == lk_ra) begin
          c_hit  = 1'b1;
          c_data = m_q[i].data;
        end
      end
      chk("lk_hit", 32'(lk_hit), 32'(c_hit));
      if (c_hit) chk("lk_data", lk_data, c_data);
`else
      chk("lk_hit", 32'(lk_hit), 32'(c_hit));
      chk("lk_data", lk_data, c_data);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [DW-1:0] data);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = data;
    cyc();
    wb_valid = 1'b0;
  endtask

  task automatic drain();
    wb_valid = 1'b0;
    gpr_busy = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (occ == '0) break;
      cyc();
    end
    chk("drain", 32'(occ), 32'd0);
  endtask

  task automatic offer_until_taken(input logic [4:0] rd, input logic [DW-1:0] data);
    bit taken;
    taken    = 1'b0;
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = data;
    for (int i = 0; i < 20; i++) begin
      taken = wb_ready;
      cyc();
      if (taken) break;
    end
    wb_valid = 1'b0;
    chk("offer_taken", 32'(taken), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_en = 1'b1;
    #1;
    chk("rst_occ", 32'(occ), 32'd0);
    chk("rst_ready", 32'(wb_ready), 32'd1);
    chk("rst_we", 32'(gpr_we), 32'd0);
    chk("rst_lk_hit", 32'(lk_hit), 32'd0);

    // T2 single pass, and no fall-through while empty
    gpr_busy = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_1234;
    #1 chk("t2_no_fallthru", 32'(gpr_we), 32'd0);
    cyc();
    wb_valid = 1'b0;
    chk("t2_we", 32'(gpr_we), 32'd1);
    chk("t2_wa", 32'(gpr_wa), 32'd5);
    chk("t2_wd", gpr_wd, 32'h0000_1234);
    cyc();
    chk("t2_occ", 32'(occ), 32'd0);

    // T3 fill / back-pressure
    wlog.delete();
    gpr_busy = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      wb_valid = 1'b1; wb_rd = 5'(k); wb_data = 32'h100 + 32'(k);
      #1 chk("t3_ready", 32'(wb_ready), 32'(k <= 4));
      cyc();
    end
    wb_valid = 1'b0;
    chk("t3_full_occ", 32'(occ), 32'd4);
    chk("t3_full_ready", 32'(wb_ready), 32'd0);
    gpr_busy = 1'b0;
    offer_until_taken(5'd5, 32'h105);
    offer_until_taken(5'd6, 32'h106);
    drain();
    chk("t3_nwrites", 32'(wlog.size()), 32'd6);
    for (int k = 0; k < 6 && k < wlog.size(); k++) begin
      chk("t3_order_rd", 32'(wlog[k].rd), 32'(k + 1));
      chk("t3_order_wd", wlog[k].data, 32'h101 + 32'(k));
    end

    // T4 simultaneous enqueue/dequeue, streaming across pointer wrap
    gpr_busy = 1'b1;
    push(5'd10, 32'hA0);
    push(5'd11, 32'hA1);
    gpr_busy = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd12; wb_data = 32'hA2;
    chk("t4_occ_pre", 32'(occ), 32'd2);
    cyc();
    chk("t4_occ_simul", 32'(occ), 32'd2);
    for (int i = 0; i < 10; i++) begin
      wb_rd = 5'($urandom_range(0, 31)); wb_data = $urandom;
      cyc();
      chk("t4_occ_stream", 32'(occ), 32'd2);
    end
    drain();

    // T1 reset mid-stream with three pending entries
    wlog.delete();
    gpr_busy = 1'b1;
    push(5'd20, 32'hD0);
    push(5'd21, 32'hD1);
    push(5'd22, 32'hD2);
    chk("t1_occ3", 32'(occ), 32'd3);
    #2;
    gpr_busy = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t1_async_we", 32'(gpr_we), 32'd0);
    chk("t1_async_occ", 32'(occ), 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    repeat (5) cyc();
    chk("t1_no_stale", 32'(wlog.size()), 32'd0);

    // T5 / T6 bypass lookup
    gpr_busy = 1'b1;
    push(5'd7, 32'hAAAA_0000);
    push(5'd3, 32'h0000_0001);
    push(5'd7, 32'hBBBB_0000);
    lk_ra = 5'd7;
    #1;
`ifdef GPR_WB_BYPASS_EN
    chk("t5_hit7", 32'(lk_hit), 32'd1);
    chk("t5_data7", lk_data, 32'hBBBB_0000);
`else
    chk("t6_hit7", 32'(lk_hit), 32'd0);
    chk("t6_data7", lk_data, 32'd0);
`endif
    lk_ra = 5'd9;
    #1 chk("t5_hit9", 32'(lk_hit), 32'd0);
    lk_ra = 5'd3;
    #1;
`ifdef GPR_WB_BYPASS_EN
    chk("t5_hit3", 32'(lk_hit), 32'd1);
    chk("t5_data3", lk_data, 32'h0000_0001);
`else
    chk("t6_hit3", 32'(lk_hit), 32'd0);
`endif
    lk_ra = 5'd7;
    drain();

    // T7 r0 is written like any other register
    push(5'd0, 32'hFFFF_FFFF);
    chk("t7_we", 32'(gpr_we), 32'd1);
    chk("t7_wa", 32'(gpr_wa), 32'd0);
    chk("t7_wd", gpr_wd, 32'hFFFF_FFFF);
    cyc();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      wb_valid = ($urandom_range(0, 3) != 0);
      if (i < 300) gpr_busy = ($urandom_range(0, 2) != 0);
      else         gpr_busy = ($urandom_range(0, 3) == 0);
      wb_rd   = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      lk_ra   = 5'($urandom_range(0, 7));
      if (i == 450) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      cyc();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
